// File: rtl/disp_source_sched_if.sv
// disp_source_sched_if: digit-word sources, message handshake and digit outputs of the display scheduler
// master drives sources/message/blink mask; slave (the scheduler) drives msg_ready, bit_7..bit_0, src_id
interface disp_source_sched_if;
  logic [31:0] src0_data;
  logic [31:0] src1_data;
  logic        src1_req;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  blink_mask;
  logic [3:0]  bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
  logic [1:0]  src_id;
  modport master (
    output src0_data, src1_data, src1_req, msg_data, msg_valid, blink_mask,
    input  msg_ready, bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0, src_id
  );
  modport slave (
    input  src0_data, src1_data, src1_req, msg_data, msg_valid, blink_mask,
    output msg_ready, bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0, src_id
  );
endinterface

// File: rtl/disp_source_sched.sv
// disp_source_sched: picks message / src1 / src0 digit word for the 8-digit scan driver with blank gaps and blink
// ports: sclk, rst (async, active high), bus (slave modport: sources, message handshake, digits, src_id)
// DISP_BLINK_EN defined enables digit blinking from blink_mask in S_SRC0/S_SRC1
module disp_source_sched #(
  parameter logic [15:0] TICK_MAX      = 16'd49_999,
  parameter logic [11:0] MSG_HOLD_MS   = 12'd2000,
  parameter logic [11:0] GAP_MS        = 12'd20,
  parameter logic [11:0] BLINK_HALF_MS = 12'd500
) (
  input logic sclk,
  input logic rst,
  disp_source_sched_if.slave bus
);
  // encoding doubles as src_id
  typedef enum logic [1:0] {S_SRC0 = 2'd0, S_SRC1 = 2'd1, S_MSG = 2'd2, S_GAP = 2'd3} state_t;
  state_t state_q, state_d, target;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic tick, acc, pend_q, pend_d, rdy_q;
  logic [11:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] msg_buf_q, msg_buf_d, bits_q, bits_d, live;
  logic [1:0] sid_q;
  logic [7:0] blank;
  assign tick       = tick_cnt_q == TICK_MAX;
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
  assign acc        = bus.msg_valid & rdy_q;
  assign target     = pend_q ? S_MSG : bus.src1_req ? S_SRC1 : S_SRC0;
  assign cnt_inc    = &cnt_q ? cnt_q : cnt_q + 12'd1;
  // gap exits to the target as sampled at exit time, so a late higher-priority request redirects it
  assign state_d = (state_q == S_GAP) ? ((tick && cnt_inc >= GAP_MS) ? target : S_GAP)
                 : (state_q == S_MSG) ? ((tick && cnt_inc >= MSG_HOLD_MS) ? S_GAP : S_MSG)
                 : (target != state_q) ? S_GAP : state_q;
  assign cnt_d     = (state_d != state_q) ? '0 : tick ? cnt_inc : cnt_q;
  assign pend_d    = acc | (pend_q & !(state_q == S_MSG && state_d == S_GAP));
  assign msg_buf_d = acc ? bus.msg_data : msg_buf_q;
  assign live      = (state_q == S_SRC1) ? bus.src1_data : bus.src0_data;
`ifdef DISP_BLINK_EN
  logic [11:0] blink_q, blink_d;
  logic phase_q, blink_wrap;
  assign blink_wrap = tick && (blink_q + 12'd1) >= BLINK_HALF_MS;
  assign blink_d    = blink_wrap ? '0 : tick ? blink_q + 12'd1 : blink_q;
  assign blank      = phase_q ? 8'h00 : bus.blink_mask;
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      blink_q <= '0;
      phase_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_q ^ blink_wrap;
    end
`else
  logic unused_mask;
  assign unused_mask = ^bus.blink_mask;
  assign blank       = 8'h00;
`endif
  for (genvar i = 0; i < 8; i++) begin : g_dig
    assign bits_d[4*i +: 4] = (state_q == S_GAP) ? 4'hA
                            : (state_q == S_MSG) ? msg_buf_q[4*i +: 4]
                            : blank[i] ? 4'hA : live[4*i +: 4];
  end
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      state_q    <= S_SRC0;
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rdy_q      <= 1'b0;
      msg_buf_q  <= '0;
      bits_q     <= {8{4'hA}};
      sid_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rdy_q      <= !pend_d;
      msg_buf_q  <= msg_buf_d;
      bits_q     <= bits_d;
      sid_q      <= state_q;
    end
  assign {bus.bit_7, bus.bit_6, bus.bit_5, bus.bit_4, bus.bit_3, bus.bit_2, bus.bit_1, bus.bit_0} = bits_q;
  assign bus.src_id    = sid_q;
  assign bus.msg_ready = rdy_q;
endmodule

// File: tb/tb_disp_source_sched.sv
// tb_disp_source_sched: randomized self-checking bench against an edge-indexed reference model
module tb_disp_source_sched;
  localparam int TP = 10, HOLD = 5, GAP = 2, BH = 3;
`ifdef DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  disp_source_sched_if bus();
  disp_source_sched #(.TICK_MAX(16'd9), .MSG_HOLD_MS(12'd5), .GAP_MS(12'd2), .BLINK_HALF_MS(12'd3))
    dut (.sclk(clk), .rst(rst), .bus(bus));
  int total = 0, bad = 0;
  int k, e, mode;
  bit pend, rdy, exp_rdy;
  logic [31:0] mbuf, exp_bits, obs;
  logic [1:0] exp_id;
  assign obs = {bus.bit_7, bus.bit_6, bus.bit_5, bus.bit_4, bus.bit_3, bus.bit_2, bus.bit_1, bus.bit_0};
  // ticks that have happened at edges 0..n since reset release
  function automatic int tcount(int n);
    return (n + 1) / TP;
  endfunction
  // blink phase in force just before edge n
  function automatic bit phase_at(int n);
    return ((tcount(n - 1) / BH) % 2) == 0;
  endfunction
  task automatic model_reset();
    k = 0; e = 0; mode = 0; pend = 0; rdy = 0; mbuf = '0;
  endtask
  // advance model by one edge from the current inputs, then move to just after that edge
  task automatic step();
    bit tk, acc;
    int tgt;
    logic [31:0] src;
    src = (mode == 1) ? bus.src1_data : bus.src0_data;
    for (int i = 0; i < 8; i++)
      exp_bits[4*i +: 4] = (mode == 3) ? 4'hA : (mode == 2) ? mbuf[4*i +: 4]
                         : (BLINK && !phase_at(k) && bus.blink_mask[i]) ? 4'hA : src[4*i +: 4];
    exp_id = mode[1:0];
    acc = bus.msg_valid && rdy;
    tgt = pend ? 2 : bus.src1_req ? 1 : 0;
    tk = (k % TP) == TP - 1;
    if (mode < 2 && tgt != mode) begin mode = 3; e = k; end
    else if (mode == 3 && tk && tcount(k) - tcount(e) == GAP) begin mode = tgt; e = k; end
    else if (mode == 2 && tk && tcount(k) - tcount(e) == HOLD) begin mode = 3; e = k; pend = 0; end
    if (acc) begin pend = 1; mbuf = bus.msg_data; end
    rdy = !pend;
    exp_rdy = rdy;
    k++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.src0_data = 32'h1230_4559; bus.src1_data = '0; bus.src1_req = 0;
    bus.msg_data = '0; bus.msg_valid = 0; bus.blink_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (obs !== 32'hAAAA_AAAA) begin bad++; $display("FAIL reset_bits got=%h exp=aaaaaaaa", obs); end
    total++; if (bus.msg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.msg_ready); end
    total++; if (bus.src_id !== 2'd0) begin bad++; $display("FAIL reset_src_id got=%0d exp=0", bus.src_id); end
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (2) begin
      step();
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL reset_release k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (obs !== 32'h1230_4559) begin bad++; $display("FAIL release_bits got=%h exp=12304559", obs); end
    total++; if (bus.msg_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", bus.msg_ready); end
  endtask
  task automatic test_message();
    int n2 = 0;
    bus.msg_data = 32'hBBBB_BBBB; bus.msg_valid = 1;
    step();
    bus.msg_valid = 0; bus.msg_data = $urandom;
    total++; if (bus.msg_ready !== 1'b0) begin bad++; $display("FAIL msg_accept_ready got=%b exp=0", bus.msg_ready); end
    for (int c = 0; c < 150; c++) begin
      if (c % 7 == 0) bus.src0_data = $urandom;
      step();
      if (bus.src_id == 2'd2) n2++;
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL message k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (n2 < (HOLD - 1) * TP + 1 || n2 > HOLD * TP) begin bad++; $display("FAIL msg_hold_len got=%0d exp=%0d..%0d", n2, (HOLD - 1) * TP + 1, HOLD * TP); end
    total++; if (bus.src_id !== 2'd0 || bus.msg_ready !== 1'b1) begin bad++; $display("FAIL msg_return got=%0d/%b exp=0/1", bus.src_id, bus.msg_ready); end
  endtask
  task automatic test_priority();
    int n3 = 0;
    bus.src1_data = 32'h2024_0B15; bus.src1_req = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.src_id == 2'd3) n3++;
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL priority_up k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (n3 < (GAP - 1) * TP + 1 || n3 > GAP * TP) begin bad++; $display("FAIL gap_len got=%0d exp=%0d..%0d", n3, (GAP - 1) * TP + 1, GAP * TP); end
    total++; if (obs !== 32'h2024_0B15 || bus.src_id !== 2'd1) begin bad++; $display("FAIL src1_shown got=%h/%0d exp=20240b15/1", obs, bus.src_id); end
    bus.src1_req = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL priority_down k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (bus.src_id !== 2'd0) begin bad++; $display("FAIL src0_back got=%0d exp=0", bus.src_id); end
  endtask
  task automatic test_simultaneous();
    bit seen2 = 0, via0 = 0;
    bus.msg_data = 32'h9876_5432; bus.msg_valid = 1; bus.src1_req = 1; bus.src1_data = $urandom;
    step();
    bus.msg_valid = 0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (bus.src_id == 2'd2) seen2 = 1;
      if (seen2 && bus.src_id == 2'd0) via0 = 1;
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL simult k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (!seen2 || via0 || bus.src_id !== 2'd1) begin bad++; $display("FAIL simult_order got=seen_msg%0b/via_src0%0b/id%0d exp=1/0/1", seen2, via0, bus.src_id); end
    bus.src1_req = 0;
    repeat (40) step();
  endtask
  task automatic test_blink();
    int tog = 0, last = -1, n7 = 0, badgap = 0;
    logic [3:0] p0, p7;
    bus.blink_mask = 8'h03; bus.src0_data = 32'h8765_4321;
    step();
    p0 = bus.bit_0; p7 = bus.bit_7;
    for (int c = 0; c < 130; c++) begin
      step();
      if (bus.bit_0 !== p0) begin
        if (last >= 0 && c - last != BH * TP) badgap++;
        last = c; tog++;
      end
      if (bus.bit_7 !== p7) n7++;
      p0 = bus.bit_0; p7 = bus.bit_7;
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL blink k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (BLINK ? (tog < 3 || badgap != 0) : (tog != 0)) begin bad++; $display("FAIL blink_toggles got=%0d/%0d exp=%s", tog, badgap, BLINK ? ">=3/0" : "0"); end
    total++; if (n7 != 0) begin bad++; $display("FAIL blink_steady got=%0d exp=0", n7); end
    bus.blink_mask = '0;
  endtask
  task automatic test_reset_mid_msg();
    bit found = 0, reshown = 0;
    bus.msg_data = 32'h1357_9BDF; bus.msg_valid = 1;
    step();
    bus.msg_valid = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      found = bus.src_id == 2'd2;
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL rstmsg_pre k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rstmsg_reach got=no_msg exp=src_id2"); end
    #2 rst = 1'b1;
    #1;
    total++; if ({obs, bus.src_id, bus.msg_ready} !== {32'hAAAA_AAAA, 2'd0, 1'b0}) begin bad++; $display("FAIL rstmsg_async got=%h/%0d/%b exp=aaaaaaaa/0/0", obs, bus.src_id, bus.msg_ready); end
    @(negedge clk) rst = 1'b0;
    model_reset();
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus.src_id == 2'd2) reshown = 1;
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL rstmsg_post k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
    total++; if (reshown || obs !== bus.src0_data) begin bad++; $display("FAIL rstmsg_discard got=%0b/%h exp=0/%h", reshown, obs, bus.src0_data); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.src0_data = $urandom; bus.src1_data = $urandom; bus.msg_data = $urandom;
      if ($urandom_range(0, 49) == 0) bus.src1_req = !bus.src1_req;
      if ($urandom_range(0, 29) == 0) bus.blink_mask = 8'($urandom);
      bus.msg_valid = $urandom_range(0, 39) == 0;
      step();
      total++;
      if ({obs, bus.src_id, bus.msg_ready} !== {exp_bits, exp_id, exp_rdy}) begin
        bad++; $display("FAIL random k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs, bus.src_id, bus.msg_ready, exp_bits, exp_id, exp_rdy);
      end
    end
  endtask
  initial begin
    test_reset();
    test_message();
    test_priority();
    test_simultaneous();
    test_blink();
    test_reset_mid_msg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/disp_source_sched.md
# disp_source_sched

Display-source scheduler for the 8-digit multiplexed seven-segment driver. It chooses which 32-bit digit word (eight 4-bit digit codes) feeds the scan driver's digit inputs from three sources, in priority order: a one-shot message, an alternate source (e.g. date or settings), and a default source (e.g. DS1302 time). It holds each message for a fixed time, inserts a blank gap on every source switch, and can blink selected digits. It sits between the time/date formatting logic and the digit-scan driver.

## Interface
- TICK_MAX, 16'd49_999, last value of the 1 ms tick divider (50 MHz sclk)
- MSG_HOLD_MS, 12'd2000, message display time in ticks (1..4095)
- GAP_MS, 12'd20, blank gap between sources in ticks (1..4095)
- BLINK_HALF_MS, 12'd500, blink half-period in ticks (1..4095)

- sclk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- src0_data  in  32  default digit word; [31:28]→bit_7 … [3:0]→bit_0
- src1_data  in  32  alternate digit word
- src1_req  in  1  level: show src1 instead of src0
- msg_data  in  32  message digit word, sampled on handshake
- msg_valid  in  1  message offered
- msg_ready  out  1  message can be accepted
- blink_mask  in  8  bit i set → bit_i blinks (src0/src1 only)
- bit_7 … bit_0  out  4 each  digit codes to scan driver (4'hA = blank)
- src_id  out  2  0=src0, 1=src1, 2=message, 3=gap

## Operation
- Tick: cnt_1ms counts 0..TICK_MAX and wraps; tick is a one-cycle pulse at the wrap.
- Message accept: msg_valid & msg_ready at an edge → msg_buf <= msg_data, msg_pending <= 1. msg_ready = !msg_pending, registered (low for the cycle after accept). msg_pending clears when S_MSG exits.
- Target each cycle: msg_pending ? MSG : src1_req ? SRC1 : SRC0.
- States: S_SRC0 (reset), S_SRC1, S_MSG, S_GAP.
  - S_SRC0/S_SRC1: if target ≠ current → S_GAP, gap counter cleared.
  - S_GAP: increments on tick. At GAP_MS → target. Target is re-evaluated on exit, so a higher-priority request arriving mid-gap redirects without restarting the gap.
  - S_MSG: hold counter cleared on entry and incremented on tick. At MSG_HOLD_MS → clear msg_pending, → S_GAP. src1_req changes are ignored while in S_MSG.
- Output data per state:
  - S_SRC0: src0_data, live.
  - S_SRC1: src1_data, live.
  - S_MSG: msg_buf.
  - S_GAP: all 4'hA.
- Blink: a phase flag toggles every BLINK_HALF_MS ticks and is 1 (on) after reset. In S_SRC0/S_SRC1, when the phase is 0, digits whose mask bit is set output 4'hA.
- Counters saturate at 12 bits. Parameter values of 0 are illegal.

## Timing
- Reset values:
  - all bit_* = 4'hA
  - src_id = 0
  - msg_ready = 0
  - state = S_SRC0
  - msg_pending = 0
  - all counters = 0
  - blink phase = 1
- After rst falls: msg_ready = 1 at the first edge; bits show src0_data at the first edge.
- Outputs are registered: bits and src_id reflect the state and inputs of the previous cycle (1-cycle latency from a source-data change).
- Accept at edge N → S_GAP at N+1 → bits blank at N+2.
- A gap lasts between GAP_MS−1 and GAP_MS tick periods (tick phase not reset). The same bound applies to the message hold.
- rst mid-message: the message is discarded and all reset values apply immediately.

## Configuration
- DISP_BLINK_EN defined: blink phase counter and masking as above.
- DISP_BLINK_EN undefined: blink logic absent. blink_mask remains a port but is ignored, and digits are never blanked in S_SRC0/S_SRC1.

## Test plan
Bench parameters: TICK_MAX=9, MSG_HOLD_MS=5, GAP_MS=2, BLINK_HALF_MS=3.
- Reset: hold rst with src0_data=32'h1230_4559 → all bits 4'hA, msg_ready=0, src_id=0. After release → bits 1,2,3,0,4,5,5,9 and msg_ready=1 by the 2nd edge.
- Message: pulse msg_valid with 32'hBBBB_BBBB → msg_ready=0, then:
  - src_id=3 with blanks for ~20 cycles
  - all 4'hB, src_id=2 for ~50 cycles
  - gap, then src0 returns
  - msg_ready=1 once back in S_SRC0
- Priority: raise src1_req (src1_data=32'h2024_0B15) → gap, then src1 digits, src_id=1. Drop src1_req → gap, then src0.
- Simultaneous: msg_valid and src1_req rise on the same edge → message shown first; after its gap, src1 is shown without passing through src0.
- Blink (macro on): blink_mask=8'h03 → bit_1/bit_0 alternate data/4'hA every 30 cycles; other digits steady. Macro off → all digits steady.
- Reset mid-message: assert rst during S_MSG → bits 4'hA, msg_pending cleared. After release → src0 shown, and the old message is not reshown.
